// File: rtl/arb_rr_hold_if.sv
// Request/grant handshake bundle between the requesters, the round-robin
// arbiter and the downstream consumer.
interface arb_rr_hold_if #(
  parameter int WIDTH = 32
);
  localparam int IDX_W = $clog2(WIDTH);

  logic [WIDTH-1:0] req;
  logic             ack;
  logic [WIDTH-1:0] gnt;
  logic [IDX_W-1:0] idx;
  logic             vld;
  logic             tmo;

  modport master (output req, ack, input gnt, idx, vld, tmo);
  modport slave  (input req, ack, output gnt, idx, vld, tmo);
endinterface

// File: rtl/arb_rr_hold.sv
// Round-robin arbiter with a registered one-hot grant held until ack or an
// optional hold timeout; the last-served requester drops to lowest priority.
module arb_rr_hold #(
  parameter int WIDTH     = 32,
  parameter     DIRECTION = "LSB",
  parameter int MAX_HOLD  = 0
) (
  input logic          clk,
  input logic          rst,
  arb_rr_hold_if.slave bus
);
  localparam int IDX_W = $clog2(WIDTH);
  localparam int CNT_W = (MAX_HOLD > 0) ? $clog2(MAX_HOLD + 1) : 1;
  localparam bit IS_LSB = (DIRECTION == "LSB");

  if (DIRECTION != "LSB" && DIRECTION != "MSB") begin : g_bad_dir
    $fatal(1, "arb_rr_hold: DIRECTION must be LSB or MSB");
  end
  if (WIDTH < 2) begin : g_bad_width
    $fatal(1, "arb_rr_hold: WIDTH must be at least 2");
  end

  typedef enum logic {S_IDLE, S_GRANT} state_t;

  state_t           state_q, state_d;
  logic [WIDTH-1:0] gnt_q, gnt_d;
  logic [IDX_W-1:0] idx_q, idx_d;
  logic [IDX_W-1:0] ptr_q, ptr_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic             tmo_q, tmo_d;
  logic [IDX_W:0]   pick;
  logic             hold_expired;

  // Returns {found, index}; the pointer position itself is visited last and
  // wrap-around is done modulo WIDTH, not modulo 2**IDX_W.
  function automatic logic [IDX_W:0] rr_pick(input logic [WIDTH-1:0] r,
                                             input logic [IDX_W-1:0] p);
    logic [IDX_W:0]   res;
    logic [IDX_W-1:0] pos;
    res = '0;
    for (int k = WIDTH; k >= 1; k--) begin
      if (IS_LSB) pos = IDX_W'((int'(p) + k) % WIDTH);
      else        pos = IDX_W'((int'(p) - k + WIDTH) % WIDTH);
      if (r[pos]) res = {1'b1, pos};
    end
    return res;
  endfunction

  always_comb begin
    state_d      = state_q;
    gnt_d        = gnt_q;
    idx_d        = idx_q;
    ptr_d        = ptr_q;
    cnt_d        = cnt_q;
    tmo_d        = 1'b0;
    hold_expired = (MAX_HOLD > 0) && (int'(cnt_q) == MAX_HOLD - 1);
    pick         = rr_pick(bus.req, (state_q == S_IDLE) ? ptr_q : idx_q);

    case (state_q)
      S_IDLE: begin
        if (pick[IDX_W]) begin
          state_d            = S_GRANT;
          gnt_d              = '0;
          gnt_d[pick[IDX_W-1:0]] = 1'b1;
          idx_d              = pick[IDX_W-1:0];
          cnt_d              = '0;
        end
      end
      S_GRANT: begin
        if (bus.ack || hold_expired) begin
          // ack takes precedence over a simultaneous timeout
          ptr_d = idx_q;
          cnt_d = '0;
          tmo_d = !bus.ack;
          gnt_d = '0;
          if (pick[IDX_W]) begin
            gnt_d[pick[IDX_W-1:0]] = 1'b1;
            idx_d                  = pick[IDX_W-1:0];
          end else begin
            state_d = S_IDLE;
          end
        end else if (MAX_HOLD > 0) begin
          cnt_d = cnt_q + 1'b1;
        end
      end
      default: begin
        state_d = S_IDLE;
        gnt_d   = '0;
      end
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q <= S_IDLE;
      gnt_q   <= '0;
      idx_q   <= '0;
      ptr_q   <= IS_LSB ? IDX_W'(WIDTH - 1) : '0;
      cnt_q   <= '0;
      tmo_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      gnt_q   <= gnt_d;
      idx_q   <= idx_d;
      ptr_q   <= ptr_d;
      cnt_q   <= cnt_d;
      tmo_q   <= tmo_d;
    end
  end

  assign bus.gnt = gnt_q;
  assign bus.idx = idx_q;
  assign bus.vld = (state_q == S_GRANT);
  assign bus.tmo = tmo_q;
endmodule

// File: tb/tb_arb_rr_hold.sv
// Drives four arbiter configurations with shared stimulus and checks them
// against a list-based round-robin reference model plus directed constants.
module tb_arb_rr_hold;
  logic       clk = 1'b0;
  logic       rst = 1'b0;
  logic [4:0] req = '0;
  logic       ack = 1'b0;
  int         n_cmp = 0;
  int         n_fail = 0;

  always #5 clk = ~clk;

  arb_rr_hold_if #(.WIDTH(4)) bus0 ();
  arb_rr_hold_if #(.WIDTH(4)) bus1 ();
  arb_rr_hold_if #(.WIDTH(4)) bus2 ();
  arb_rr_hold_if #(.WIDTH(5)) bus3 ();

  assign bus0.req = req[3:0];
  assign bus1.req = req[3:0];
  assign bus2.req = req[3:0];
  assign bus3.req = req;
  assign bus0.ack = ack;
  assign bus1.ack = ack;
  assign bus2.ack = ack;
  assign bus3.ack = ack;

  arb_rr_hold #(.WIDTH(4), .DIRECTION("LSB"), .MAX_HOLD(0)) u_lsb (.clk(clk), .rst(rst), .bus(bus0));
  arb_rr_hold #(.WIDTH(4), .DIRECTION("MSB"), .MAX_HOLD(0)) u_msb (.clk(clk), .rst(rst), .bus(bus1));
  arb_rr_hold #(.WIDTH(4), .DIRECTION("LSB"), .MAX_HOLD(3)) u_tmo (.clk(clk), .rst(rst), .bus(bus2));
  arb_rr_hold #(.WIDTH(5), .DIRECTION("MSB"), .MAX_HOLD(2)) u_odd (.clk(clk), .rst(rst), .bus(bus3));

  logic [7:0] o_gnt [4];
  logic [3:0] o_idx [4];
  logic       o_vld [4];
  logic       o_tmo [4];

  assign o_gnt[0] = {4'b0, bus0.gnt};
  assign o_gnt[1] = {4'b0, bus1.gnt};
  assign o_gnt[2] = {4'b0, bus2.gnt};
  assign o_gnt[3] = {3'b0, bus3.gnt};
  assign o_idx[0] = {2'b0, bus0.idx};
  assign o_idx[1] = {2'b0, bus1.idx};
  assign o_idx[2] = {2'b0, bus2.idx};
  assign o_idx[3] = {1'b0, bus3.idx};
  assign o_vld[0] = bus0.vld;
  assign o_vld[1] = bus1.vld;
  assign o_vld[2] = bus2.vld;
  assign o_vld[3] = bus3.vld;
  assign o_tmo[0] = bus0.tmo;
  assign o_tmo[1] = bus1.tmo;
  assign o_tmo[2] = bus2.tmo;
  assign o_tmo[3] = bus3.tmo;

  // Reference model: owner (-1 when idle), last-served pointer, cycles held.
  int m_w   [4] = '{4, 4, 4, 5};
  bit m_lsb [4] = '{1'b1, 1'b0, 1'b1, 1'b0};
  int m_mh  [4] = '{0, 0, 3, 2};
  int m_own [4];
  int m_ptr [4];
  int m_age [4];
  int m_last[4];
  bit m_tmo [4];

  function automatic int pick(int d, logic [7:0] r, int p);
    int order[$];
    if (m_lsb[d]) begin
      for (int i = p + 1; i < m_w[d]; i++) order.push_back(i);
      for (int i = 0; i <= p; i++)         order.push_back(i);
    end else begin
      for (int i = p - 1; i >= 0; i--)     order.push_back(i);
      for (int i = m_w[d] - 1; i >= p; i--) order.push_back(i);
    end
    foreach (order[j]) if (r[order[j]]) return order[j];
    return -1;
  endfunction

  task automatic model_reset();
    for (int d = 0; d < 4; d++) begin
      m_own[d]  = -1;
      m_ptr[d]  = m_lsb[d] ? m_w[d] - 1 : 0;
      m_age[d]  = 0;
      m_last[d] = 0;
      m_tmo[d]  = 1'b0;
    end
  endtask

  task automatic model_step();
    for (int d = 0; d < 4; d++) begin
      logic [7:0] r;
      int         nxt;
      bit         forced;
      r = 8'(req) & 8'((1 << m_w[d]) - 1);
      if (m_own[d] < 0) begin
        if (r != 0) begin
          m_own[d]  = pick(d, r, m_ptr[d]);
          m_last[d] = m_own[d];
          m_age[d]  = 0;
        end
        m_tmo[d] = 1'b0;
      end else begin
        forced = (m_mh[d] > 0) && !ack && (m_age[d] + 1 == m_mh[d]);
        if (ack || forced) begin
          m_ptr[d] = m_own[d];
          nxt      = pick(d, r, m_own[d]);
          m_own[d] = nxt;
          if (nxt >= 0) m_last[d] = nxt;
          m_age[d] = 0;
        end else begin
          m_age[d]++;
        end
        m_tmo[d] = forced;
      end
    end
  endtask

  task automatic chk(string tag, logic [31:0] obs, logic [31:0] exp);
    n_cmp++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic compare_all(string tag);
    for (int d = 0; d < 4; d++) begin
      logic [7:0] e_gnt;
      e_gnt = (m_own[d] >= 0) ? 8'(1 << m_own[d]) : 8'h00;
      chk($sformatf("%s/dut%0d {gnt,idx,vld,tmo}", tag, d),
          32'({o_gnt[d], o_idx[d], o_vld[d], o_tmo[d]}),
          32'({e_gnt, 4'(m_last[d]), m_own[d] >= 0, m_tmo[d]}));
    end
  endtask

  task automatic step(string tag);
    model_step();
    @(posedge clk);
    #1;
    $display("%s req=%b ack=%b gnt=%b/%b/%b/%b tmo=%b%b%b%b", tag, req, ack,
             o_gnt[0][3:0], o_gnt[1][3:0], o_gnt[2][3:0], o_gnt[3][4:0],
             o_tmo[0], o_tmo[1], o_tmo[2], o_tmo[3]);
    compare_all(tag);
  endtask

  task automatic do_reset();
    req = '0;
    ack = 1'b0;
    rst = 1'b1;
    model_reset();
    @(posedge clk);
    #1;
    rst = 1'b0;
    compare_all("reset");
  endtask

  initial begin
    // 1: LSB first grant and hold
    do_reset();
    req = 5'b01010; ack = 1'b0;
    step("t1_first");
    chk("t1_gnt", 32'(o_gnt[0]), 32'h2);
    chk("t1_idx", 32'(o_idx[0]), 32'd1);
    for (int i = 0; i < 10; i++) begin
      step("t1_hold");
      chk("t1_hold_gnt", 32'(o_gnt[0]), 32'h2);
    end
    // 2: rotation with no bubble
    ack = 1'b1;
    step("t2_ack1");
    chk("t2_gnt_b2b", 32'(o_gnt[0]), 32'h8);
    chk("t2_idx", 32'(o_idx[0]), 32'd3);
    step("t2_ack2");
    chk("t2_gnt_wrap", 32'(o_gnt[0]), 32'h2);
    // 3: MSB direction and drop to idle
    do_reset();
    req = 5'b00101; ack = 1'b0;
    step("t3_first");
    chk("t3_gnt", 32'(o_gnt[1]), 32'h4);
    chk("t3_idx", 32'(o_idx[1]), 32'd2);
    ack = 1'b1;
    step("t3_ack");
    chk("t3_gnt_next", 32'(o_gnt[1]), 32'h1);
    req = '0;
    step("t3_idle");
    chk("t3_gnt_idle", 32'(o_gnt[1]), 32'h0);
    chk("t3_vld_idle", 32'(o_vld[1]), 32'h0);
    // 4: hold timeout, then ack in the last allowed cycle
    do_reset();
    req = 5'b00011; ack = 1'b0;
    for (int i = 0; i < 3; i++) begin
      step("t4_hold");
      chk("t4_gnt_hold", 32'(o_gnt[2]), 32'h1);
      chk("t4_tmo_hold", 32'(o_tmo[2]), 32'h0);
    end
    step("t4_timeout");
    chk("t4_gnt_forced", 32'(o_gnt[2]), 32'h2);
    chk("t4_tmo_pulse", 32'(o_tmo[2]), 32'h1);
    step("t4_after");
    chk("t4_tmo_once", 32'(o_tmo[2]), 32'h0);
    do_reset();
    req = 5'b00011; ack = 1'b0;
    for (int i = 0; i < 3; i++) step("t4b_hold");
    ack = 1'b1;
    step("t4b_ack_at_limit");
    chk("t4b_gnt", 32'(o_gnt[2]), 32'h2);
    chk("t4b_tmo", 32'(o_tmo[2]), 32'h0);
    // 5: single requester re-granted every cycle
    do_reset();
    req = 5'b00100; ack = 1'b1;
    for (int i = 0; i < 6; i++) begin
      step("t5_single");
      chk("t5_gnt", 32'(o_gnt[0]), 32'h4);
      chk("t5_vld", 32'(o_vld[0]), 32'h1);
    end
    // 6: asynchronous reset mid-grant
    do_reset();
    req = 5'b01000; ack = 1'b0;
    step("t6_grant");
    chk("t6_gnt", 32'(o_gnt[0]), 32'h8);
    #3;
    rst = 1'b1;
    model_reset();
    #1;
    chk("t6_async_gnt", 32'(o_gnt[0]), 32'h0);
    chk("t6_async_vld", 32'(o_vld[0]), 32'h0);
    chk("t6_async_tmo", 32'(o_tmo[0]), 32'h0);
    compare_all("t6_async");
    #1;
    rst = 1'b0;
    req = 5'b01001;
    step("t6_regrant");
    chk("t6_gnt_ptr_reset", 32'(o_gnt[0]), 32'h1);
    // Random traffic across all four configurations
    do_reset();
    for (int i = 0; i < 300; i++) begin
      req = ($urandom_range(0, 3) == 0) ? 5'($urandom) & 5'($urandom) : 5'($urandom);
      ack = ($urandom_range(0, 9) < 4);
      step($sformatf("rnd%0d", i));
    end
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
    $finish;
  end
endmodule
